// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared ALU, forwarding and write-back encodings for the execute stage
package exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_BUS = 2'd0;
    localparam logic [1:0] FWD_M   = 2'd1;
    localparam logic [1:0] FWD_W   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store_data;
        logic [31:0] pcplus;
        logic [4:0]  rw;
        logic [1:0]  wb_data;
        logic        memrd;
        logic        memwr;
        logic        regwrite;
        logic        regsel;
    } m_reg_t;

    // Select 3 is unused by the hazard unit and falls back to the register bus.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] bus,
                                            input logic [31:0] m_data, input logic [31:0] w_data);
        case (sel)
            FWD_M:   fwd_mux = m_data;
            FWD_W:   fwd_mux = w_data;
            default: fwd_mux = bus;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU
module alu
    import exec_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] y
);

    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = 32'd0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage with E->M register and data-memory wait handshake
module execute_stage
    import exec_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             predicate_e,
    input  logic             pred_true_e,
    input  logic [31:0]      busa_e,
    input  logic [31:0]      busb_e,
    input  logic [31:0]      imm_e,
    input  logic [4:0]       rw_e,
    input  logic [2:0]       aluop_e,
    input  logic             alusrc_e,
    input  logic             memrd_e,
    input  logic             memwr_e,
    input  logic             regwrite_e,
    input  logic             regsel_e,
    input  logic [1:0]       wb_data_e,
    input  logic [31:0]      pcplus_e,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [31:0]      fwd_m_data,
    input  logic [31:0]      fwd_w_data,
    input  logic             mem_ready,
    output logic [31:0]      alu_m,
    output logic [31:0]      store_data_m,
    output logic [31:0]      pcplus_m,
    output logic [4:0]       rw_m,
    output logic [1:0]       wb_data_m,
    output logic             memrd_m,
    output logic             memwr_m,
    output logic             regwrite_m,
    output logic             regsel_m,
    output logic             stall_mem,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    m_reg_t            m_q;
    m_reg_t            m_next;
    logic [31:0]       op_a;
    logic [31:0]       op_bf;
    logic [31:0]       op_b;
    logic [31:0]       alu_y;
    logic              annul;
    logic              hold;
    logic [WAIT_W-1:0] wait_cnt;

    assign op_a  = fwd_mux(fwd_a_sel, busa_e, fwd_m_data, fwd_w_data);
    assign op_bf = fwd_mux(fwd_b_sel, busb_e, fwd_m_data, fwd_w_data);
    assign op_b  = alusrc_e ? imm_e : op_bf;

    alu u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (aluop_e),
        .y  (alu_y)
    );

    assign annul = predicate_e & ~pred_true_e;
    assign hold  = (m_q.memrd | m_q.memwr) & ~mem_ready;

    always_comb begin
        m_next            = '0;
        m_next.alu        = alu_y;
        m_next.store_data = op_bf;
        m_next.pcplus     = pcplus_e;
        m_next.rw         = rw_e;
        m_next.wb_data    = wb_data_e;
        m_next.memrd      = memrd_e;
        m_next.memwr      = memwr_e;
        m_next.regwrite   = regwrite_e;
        m_next.regsel     = regsel_e;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q         <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (hold) begin
                m_q <= m_q;
            end else if (annul) begin
                m_q <= '0;
            end else begin
                m_q <= m_next;
            end

            // The wait counter parks at MAX_WAIT so a very long hold cannot wrap it.
            if (hold) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt == WAIT_LAST) begin
                    mem_timeout <= 1'b1;
                end
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign alu_m        = m_q.alu;
    assign store_data_m = m_q.store_data;
    assign pcplus_m     = m_q.pcplus;
    assign rw_m         = m_q.rw;
    assign wb_data_m    = m_q.wb_data;
    assign memrd_m      = m_q.memrd;
    assign memwr_m      = m_q.memwr;
    assign regwrite_m   = m_q.regwrite;
    assign regsel_m     = m_q.regsel;
    assign stall_mem    = hold;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        predicate_e, pred_true_e;
    logic [31:0] busa_e, busb_e, imm_e, pcplus_e, fwd_m_data, fwd_w_data;
    logic [4:0]  rw_e;
    logic [2:0]  aluop_e;
    logic        alusrc_e, memrd_e, memwr_e, regwrite_e, regsel_e, mem_ready;
    logic [1:0]  wb_data_e, fwd_a_sel, fwd_b_sel;
    logic [31:0] alu_m, store_data_m, pcplus_m;
    logic [4:0]  rw_m;
    logic [1:0]  wb_data_m;
    logic        memrd_m, memwr_m, regwrite_m, regsel_m, stall_mem, mem_timeout;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_stage #(.MAX_WAIT(4), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .predicate_e  (predicate_e),
        .pred_true_e  (pred_true_e),
        .busa_e       (busa_e),
        .busb_e       (busb_e),
        .imm_e        (imm_e),
        .rw_e         (rw_e),
        .aluop_e      (aluop_e),
        .alusrc_e     (alusrc_e),
        .memrd_e      (memrd_e),
        .memwr_e      (memwr_e),
        .regwrite_e   (regwrite_e),
        .regsel_e     (regsel_e),
        .wb_data_e    (wb_data_e),
        .pcplus_e     (pcplus_e),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .fwd_m_data   (fwd_m_data),
        .fwd_w_data   (fwd_w_data),
        .mem_ready    (mem_ready),
        .alu_m        (alu_m),
        .store_data_m (store_data_m),
        .pcplus_m     (pcplus_m),
        .rw_m         (rw_m),
        .wb_data_m    (wb_data_m),
        .memrd_m      (memrd_m),
        .memwr_m      (memwr_m),
        .regwrite_m   (regwrite_m),
        .regsel_m     (regsel_m),
        .stall_mem    (stall_mem),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_e();
        predicate_e = 0; pred_true_e = 0;
        busa_e = 0; busb_e = 0; imm_e = 0; pcplus_e = 0;
        fwd_m_data = 0; fwd_w_data = 0; rw_e = 0; aluop_e = 0;
        alusrc_e = 0; memrd_e = 0; memwr_e = 0; regwrite_e = 0; regsel_e = 0;
        wb_data_e = 0; fwd_a_sel = 0; fwd_b_sel = 0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_alu"}, alu_m, 32'd0);
        check({tag, "_store"}, store_data_m, 32'd0);
        check({tag, "_pc"}, pcplus_m, 32'd0);
        check({tag, "_ctl"}, {23'd0, rw_m, wb_data_m, memrd_m, memwr_m, regwrite_m, regsel_m}, 32'd0);
    endtask

    task automatic load_op(input logic [31:0] a, input logic [31:0] imm);
        clear_e();
        busa_e = a; imm_e = imm; alusrc_e = 1; aluop_e = 3'b000;
        memrd_e = 1; regwrite_e = 1; wb_data_e = 2'd1; rw_e = 5'd9; pcplus_e = 32'h44;
    endtask

    initial begin
        clear_e();
        reset = 1; mem_ready = 1;
        tick(); tick();
        check_bubble("reset");
        check("reset_stall", {31'd0, stall_mem}, 32'd0);
        check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        reset = 0;

        // ADD 5 + imm 7
        clear_e(); busa_e = 5; imm_e = 7; alusrc_e = 1; aluop_e = 3'b000;
        regwrite_e = 1; rw_e = 5'd4; pcplus_e = 32'h104;
        tick();
        check("add_imm", alu_m, 32'd12);
        check("add_rw", {27'd0, rw_m}, 32'd4);
        check("add_pc", pcplus_m, 32'h104);

        // signed SLT -1 < 1
        clear_e(); busa_e = 32'hFFFF_FFFF; busb_e = 1; aluop_e = 3'b111;
        tick();
        check("slt_signed", alu_m, 32'd1);

        // SUB with A forwarded from M
        clear_e(); fwd_a_sel = 2'd1; fwd_m_data = 32'h10; busb_e = 4; aluop_e = 3'b001;
        tick();
        check("sub_fwd_m", alu_m, 32'h0C);

        // store: B forwarded from W, address uses immediate
        clear_e(); busa_e = 32'h200; imm_e = 32'h8; alusrc_e = 1; fwd_b_sel = 2'd2;
        fwd_w_data = 32'hAB; busb_e = 32'h55; memwr_e = 1;
        tick();
        check("store_data", store_data_m, 32'hAB);
        check("store_addr", alu_m, 32'h208);
        check("store_memwr", {31'd0, memwr_m}, 32'd1);
        check("store_no_hold", {31'd0, stall_mem}, 32'd0);

        // SLL by B[4:0] (33 -> 1), SRL by imm, XOR, sel 3 falls back to bus
        clear_e(); busa_e = 1; busb_e = 33; aluop_e = 3'b101;
        tick();
        check("sll", alu_m, 32'd2);
        clear_e(); busa_e = 32'h8000_0000; imm_e = 4; alusrc_e = 1; aluop_e = 3'b110;
        tick();
        check("srl", alu_m, 32'h0800_0000);
        clear_e(); busa_e = 32'hF0F0_0000; busb_e = 32'h0FF0_0000; fwd_a_sel = 2'd3;
        fwd_m_data = 32'h1234; aluop_e = 3'b100;
        tick();
        check("xor_sel3", alu_m, 32'hFF00_0000);

        // annulled instruction becomes a bubble; taken predicate loads
        clear_e(); predicate_e = 1; pred_true_e = 0; regwrite_e = 1; rw_e = 5'd3;
        busa_e = 5; imm_e = 7; alusrc_e = 1; pcplus_e = 32'h300;
        tick();
        check_bubble("annul");
        pred_true_e = 1;
        tick();
        check("pred_true_alu", alu_m, 32'd12);
        check("pred_true_rw", {27'd0, rw_m}, 32'd3);

        // load held 3 cycles
        load_op(32'h100, 32'h8); mem_ready = 0;
        tick();
        check("ld_in_m", alu_m, 32'h108);
        check("ld_stall0", {31'd0, stall_mem}, 32'd1);
        clear_e(); busa_e = 1; imm_e = 2; alusrc_e = 1; predicate_e = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_alu", alu_m, 32'h108);
            check("hold_memrd", {31'd0, memrd_m}, 32'd1);
            check("hold_rw", {27'd0, rw_m}, 32'd9);
        end
        check("hold_stall", {31'd0, stall_mem}, 32'd1);
        check("hold_cnt3", {16'd0, stall_cnt}, 32'd3);
        check("hold_no_timeout", {31'd0, mem_timeout}, 32'd0);
        predicate_e = 0;
        mem_ready = 1;
        #1;
        check("ready_release", {31'd0, stall_mem}, 32'd0);
        tick();
        check("next_loaded", alu_m, 32'd3);
        check("next_memrd", {31'd0, memrd_m}, 32'd0);
        check("cnt_kept", {16'd0, stall_cnt}, 32'd3);

        // timeout after MAX_WAIT=4 consecutive holds
        load_op(32'h400, 32'h0); mem_ready = 0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("timeout_pre", {31'd0, mem_timeout}, 32'd0);
        tick();
        check("timeout_set", {31'd0, mem_timeout}, 32'd1);
        check("timeout_still_hold", {31'd0, stall_mem}, 32'd1);
        check("cnt7", {16'd0, stall_cnt}, 32'd7);
        mem_ready = 1;
        tick();
        check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
        clear_e(); reset = 1;
        tick();
        reset = 0;
        check_bubble("rst_after_to");
        check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        check("rst_cnt", {16'd0, stall_cnt}, 32'd0);

        // reset in the middle of a hold
        load_op(32'h20, 32'h4); mem_ready = 0;
        tick(); tick();
        check("midhold_stall", {31'd0, stall_mem}, 32'd1);
        clear_e(); reset = 1;
        tick();
        reset = 0;
        check_bubble("midhold_rst");
        check("midhold_stall_drop", {31'd0, stall_mem}, 32'd0);
        check("midhold_cnt", {16'd0, stall_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
